// File: rtl/memory_stage.sv
// memory_stage: load/store pipeline stage between execute and writeback.
// Accepts one op at a time, issues at most one memory request, formats load
// data and holds the result until downstream takes it.
// Optional build macro: MEMORY_STAGE_MISALIGN_CHECK_EN -- when defined,
// misaligned or illegal-size accesses are trapped (no request, misaligned_out=1);
// when undefined, low address bits are forced to the access alignment.
module memory_stage #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int REG_IDX_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     stall_prev,
  input  logic                     prev_done,
  input  logic                     next_stall,
  output logic                     done_next,
  input  logic                     load_in,
  input  logic                     store_in,
  input  logic [2:0]               funct_3_in,
  input  logic [DATA_WIDTH-1:0]    result_data_in,
  input  logic [DATA_WIDTH-1:0]    memory_store_data_in,
  input  logic [REG_IDX_WIDTH-1:0] write_register_in,
  input  logic                     writeback_enabled_in,
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic [ADDR_WIDTH-1:0]    mem_req_addr,
  output logic                     mem_req_write,
  output logic [DATA_WIDTH-1:0]    mem_req_wdata,
  output logic [3:0]               mem_req_wstrb,
  input  logic                     mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]    mem_resp_rdata,
  output logic [REG_IDX_WIDTH-1:0] write_register_out,
  output logic                     writeback_enabled_out,
  output logic [DATA_WIDTH-1:0]    writeback_data_out,
  output logic                     misaligned_out
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] REQUEST   = 2'd1;
  localparam logic [1:0] WAIT_RESP = 2'd2;
  localparam logic [1:0] HOLD      = 2'd3;

  logic [1:0]               state_q, state_d;
  logic                     store_q, store_d;
  logic [2:0]               funct3_q, funct3_d;
  logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    sdata_q, sdata_d;
  logic [REG_IDX_WIDTH-1:0] wr_reg_q, wr_reg_d;
  logic                     wb_en_q, wb_en_d;
  logic [DATA_WIDTH-1:0]    wb_data_q, wb_data_d;
  logic                     misaligned_q, misaligned_d;

  logic transfer_next, transfer_prev;
  logic is_mem, size_half, size_word, illegal, skip, mis_flag;
  logic [ADDR_WIDTH-1:0] eff_addr;
  logic [DATA_WIDTH-1:0] shifted, load_fmt;

  assign done_next     = !rst && (state_q == HOLD);
  assign transfer_next = done_next && !next_stall;
  assign stall_prev    = rst || ((state_q != IDLE) && !((state_q == HOLD) && transfer_next));
  assign transfer_prev = prev_done && !stall_prev;

  assign mem_req_valid         = !rst && (state_q == REQUEST);
  assign mem_req_addr          = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign mem_req_write         = store_q;
  assign write_register_out    = wr_reg_q;
  assign writeback_enabled_out = wb_en_q;
  assign writeback_data_out    = wb_data_q;
  assign misaligned_out        = misaligned_q;

  // Decode the incoming op: legality, alignment and the effective address.
  always_comb begin
    is_mem    = load_in || store_in;
    size_half = (funct_3_in[1:0] == 2'b01);
    size_word = (funct_3_in[1:0] == 2'b10);
    if (store_in)
      illegal = funct_3_in[2] || (funct_3_in[1:0] == 2'b11);
    else
      illegal = (funct_3_in == 3'b011) || (funct_3_in == 3'b110) || (funct_3_in == 3'b111);
    eff_addr = result_data_in[ADDR_WIDTH-1:0];
`ifdef MEMORY_STAGE_MISALIGN_CHECK_EN
    skip     = illegal || (size_half && eff_addr[0]) || (size_word && (eff_addr[1:0] != 2'b00));
    mis_flag = is_mem && skip;
`else
    // Illegal sizes are dropped without a request; aligned sizes get low bits cleared.
    skip     = illegal;
    mis_flag = 1'b0;
    if (size_half) eff_addr[0]   = 1'b0;
    if (size_word) eff_addr[1:0] = 2'b00;
`endif
  end

  // Store lane strobes and replicated write data.
  always_comb begin
    case (funct3_q[1:0])
      2'b00:   begin mem_req_wstrb = 4'b0001 << addr_q[1:0]; mem_req_wdata = {4{sdata_q[7:0]}};  end
      2'b01:   begin mem_req_wstrb = 4'b0011 << addr_q[1:0]; mem_req_wdata = {2{sdata_q[15:0]}}; end
      default: begin mem_req_wstrb = 4'b1111;                mem_req_wdata = sdata_q;            end
    endcase
  end

  // Load lane select and sign/zero extension.
  always_comb begin
    shifted = mem_resp_rdata >> {addr_q[1:0], 3'b000};
    case (funct3_q)
      3'b000:  load_fmt = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_fmt = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_fmt = {24'd0, shifted[7:0]};
      3'b101:  load_fmt = {16'd0, shifted[15:0]};
      default: load_fmt = shifted;
    endcase
  end

  // Next-state and capture logic; accepting a new op overrides the HOLD exit.
  always_comb begin
    state_d      = state_q;
    store_d      = store_q;
    funct3_d     = funct3_q;
    addr_d       = addr_q;
    sdata_d      = sdata_q;
    wr_reg_d     = wr_reg_q;
    wb_en_d      = wb_en_q;
    wb_data_d    = wb_data_q;
    misaligned_d = misaligned_q;
    if (rst) begin
      state_d      = IDLE;
      wb_en_d      = 1'b0;
      misaligned_d = 1'b0;
    end else begin
      case (state_q)
        REQUEST:   if (mem_req_ready) state_d = store_q ? HOLD : WAIT_RESP;
        WAIT_RESP: if (mem_resp_valid) begin
                     state_d   = HOLD;
                     wb_data_d = load_fmt;
                   end
        HOLD:      if (transfer_next) state_d = IDLE;
        default:   state_d = IDLE;
      endcase
      if (transfer_prev) begin
        store_d      = store_in;
        funct3_d     = funct_3_in;
        addr_d       = eff_addr;
        sdata_d      = memory_store_data_in;
        wr_reg_d     = write_register_in;
        wb_en_d      = writeback_enabled_in && !store_in && !(is_mem && skip);
        wb_data_d    = result_data_in;
        misaligned_d = mis_flag;
        state_d      = (is_mem && !skip) ? REQUEST : HOLD;
      end
    end
  end

  // State and pipeline registers.
  always_ff @(posedge clk) begin
    state_q      <= state_d;
    store_q      <= store_d;
    funct3_q     <= funct3_d;
    addr_q       <= addr_d;
    sdata_q      <= sdata_d;
    wr_reg_q     <= wr_reg_d;
    wb_en_q      <= wb_en_d;
    wb_data_q    <= wb_data_d;
    misaligned_q <= misaligned_d;
  end

endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: directed scoreboard bench for memory_stage.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_prev, prev_done = 1'b0, next_stall = 1'b0, done_next;
  logic        load_in = 1'b0, store_in = 1'b0;
  logic [2:0]  funct_3_in = '0;
  logic [31:0] result_data_in = '0, memory_store_data_in = '0;
  logic [4:0]  write_register_in = '0;
  logic        writeback_enabled_in = 1'b0;
  logic        mem_req_valid, mem_req_ready = 1'b0, mem_req_write;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_rdata = '0;
  logic [4:0]  write_register_out;
  logic        writeback_enabled_out, misaligned_out;
  logic [31:0] writeback_data_out;

  typedef struct packed {
    logic [4:0]  rd;
    logic        wb;
    logic [31:0] data;
    logic        mis;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  memory_stage #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .REG_IDX_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .stall_prev(stall_prev), .prev_done(prev_done),
    .next_stall(next_stall), .done_next(done_next), .load_in(load_in),
    .store_in(store_in), .funct_3_in(funct_3_in), .result_data_in(result_data_in),
    .memory_store_data_in(memory_store_data_in), .write_register_in(write_register_in),
    .writeback_enabled_in(writeback_enabled_in), .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr), .mem_req_write(mem_req_write),
    .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .write_register_out(write_register_out), .writeback_enabled_out(writeback_enabled_out),
    .writeback_data_out(writeback_data_out), .misaligned_out(misaligned_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one op onto the upstream inputs and optionally record its result.
  task automatic set_op(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] res, input logic [31:0] sd, input logic [4:0] rd,
                        input logic push, input exp_t e);
    load_in = ld; store_in = st; funct_3_in = f3; result_data_in = res;
    memory_store_data_in = sd; write_register_in = rd; writeback_enabled_in = 1'b1;
    prev_done = 1'b1;
    if (push) sb.push_back(e);
  endtask

  // Load with immediate ready and a response the cycle after acceptance of the request.
  task automatic do_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata,
                         input logic [4:0] rd, input logic [31:0] exp_data,
                         input logic [31:0] exp_addr, input string name);
    @(negedge clk);
    set_op(1'b1, 1'b0, f3, addr, 32'd0, rd, 1'b1, '{rd: rd, wb: 1'b1, data: exp_data, mis: 1'b0});
    @(posedge clk); #1 prev_done = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk);
    check({name, " req"}, {31'd0, mem_req_valid, mem_req_addr}, {31'd0, 1'b1, exp_addr});
    @(posedge clk); #1 mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_rdata = rdata;
    @(posedge clk); #1 mem_resp_valid = 1'b0;
    @(negedge clk);
    check({name, " done"}, {63'd0, done_next}, 64'd1);
    @(posedge clk); #1;
  endtask

  // Monitor: every downstream transfer is matched against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && done_next && !next_stall) begin
      if (sb.size() == 0) begin
        check("unexpected_result", {26'd0, write_register_out, writeback_enabled_out,
              writeback_data_out}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", {25'd0, write_register_out, writeback_enabled_out, writeback_data_out,
              misaligned_out}, {25'd0, e});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst stall_prev", {63'd0, stall_prev}, 64'd1);
    check("rst done_next", {63'd0, done_next}, 64'd0);
    check("rst mem_req_valid", {63'd0, mem_req_valid}, 64'd0);
    check("rst misaligned", {63'd0, misaligned_out}, 64'd0);
    check("rst wb_en", {63'd0, writeback_enabled_out}, 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Back-to-back ALU ops with no bubble
    @(negedge clk);
    set_op(1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'd0, 5'd3, 1'b1,
           '{rd: 5'd3, wb: 1'b1, data: 32'h0000_1234, mis: 1'b0});
    @(posedge clk); #1;
    set_op(1'b0, 1'b0, 3'b000, 32'h0000_5678, 32'd0, 5'd4, 1'b1,
           '{rd: 5'd4, wb: 1'b1, data: 32'h0000_5678, mis: 1'b0});
    @(negedge clk);
    check("alu1 done", {63'd0, done_next}, 64'd1);
    check("alu1 stall_prev", {63'd0, stall_prev}, 64'd0);
    @(posedge clk); #1 prev_done = 1'b0;
    @(negedge clk);
    check("alu2 done", {63'd0, done_next}, 64'd1);
    @(posedge clk); #1;

    // LB at 0x103: sign-extended top byte, done 4 cycles after accept
    @(negedge clk);
    set_op(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'd0, 5'd5, 1'b1,
           '{rd: 5'd5, wb: 1'b1, data: 32'hFFFF_FF80, mis: 1'b0});
    @(posedge clk); #1 prev_done = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk);
    check("lb req", {30'd0, mem_req_valid, mem_req_write, mem_req_addr}, {30'd0, 2'b10, 32'h0000_0100});
    @(posedge clk); #1 mem_req_ready = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 mem_resp_valid = 1'b1; mem_resp_rdata = 32'h80FF_FF12;
    @(negedge clk);
    check("lb not yet done", {63'd0, done_next}, 64'd0);
    @(posedge clk); #1 mem_resp_valid = 1'b0;
    @(negedge clk);
    check("lb done at 4", {63'd0, done_next}, 64'd1);
    @(posedge clk); #1;

    // Halfword/byte load formatting
    do_load(3'b101, 32'h0000_0102, 32'h80FF_1234, 5'd9,  32'h0000_80FF, 32'h0000_0100, "lhu");
    do_load(3'b001, 32'h0000_0100, 32'h1234_8001, 5'd10, 32'hFFFF_8001, 32'h0000_0100, "lh");
    do_load(3'b100, 32'h0000_0101, 32'h0000_C300, 5'd11, 32'h0000_00C3, 32'h0000_0100, "lbu");

    // SH at 0x202 with ready low 3 cycles, then downstream stalled in HOLD
    next_stall = 1'b1;
    @(negedge clk);
    set_op(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h0000_BEEF, 5'd6, 1'b1,
           '{rd: 5'd6, wb: 1'b0, data: 32'h0000_0202, mis: 1'b0});
    @(posedge clk); #1 prev_done = 1'b0; mem_resp_valid = 1'b1; mem_resp_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("sh req", {26'd0, mem_req_valid, mem_req_write, mem_req_addr, mem_req_wstrb},
            {26'd0, 2'b11, 32'h0000_0200, 4'b1100});
      check("sh wdata", {32'd0, mem_req_wdata}, {32'd0, 32'hBEEF_BEEF});
      if (i == 3) mem_req_ready = 1'b1;
    end
    @(posedge clk); #1 mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("sh hold outputs", {24'd0, done_next, stall_prev, write_register_out,
            writeback_enabled_out, writeback_data_out, misaligned_out},
            {24'd0, 2'b11, 5'd6, 1'b0, 32'h0000_0202, 1'b0});
    end
    @(posedge clk); #1 next_stall = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;

    // LW at 0x001
`ifdef MEMORY_STAGE_MISALIGN_CHECK_EN
    @(negedge clk);
    set_op(1'b1, 1'b0, 3'b010, 32'h0000_0001, 32'd0, 5'd7, 1'b1,
           '{rd: 5'd7, wb: 1'b0, data: 32'h0000_0001, mis: 1'b1});
    @(posedge clk); #1 prev_done = 1'b0;
    @(negedge clk);
    check("lw mis no req", {63'd0, mem_req_valid}, 64'd0);
    check("lw mis done", {63'd0, done_next}, 64'd1);
    @(posedge clk); #1;
`else
    do_load(3'b010, 32'h0000_0001, 32'hCAFE_F00D, 5'd7, 32'hCAFE_F00D, 32'h0000_0000, "lw forced");
`endif

    // Reset while waiting for a load response; the late response is dropped
    @(negedge clk);
    set_op(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'd0, 5'd8, 1'b0, '0);
    @(posedge clk); #1 prev_done = 1'b0; mem_req_ready = 1'b1;
    @(posedge clk); #1 mem_req_ready = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("rst mid stall_prev", {63'd0, stall_prev}, 64'd1);
    check("rst mid req_valid", {63'd0, mem_req_valid}, 64'd0);
    check("rst mid done", {63'd0, done_next}, 64'd0);
    @(posedge clk); #1 rst = 1'b0; mem_resp_valid = 1'b1; mem_resp_rdata = 32'h1111_1111;
    @(negedge clk);
    check("post rst idle", {62'd0, done_next, stall_prev}, 64'd0);
    @(posedge clk); #1 mem_resp_valid = 1'b0;
    @(negedge clk);
    check("late resp ignored", {63'd0, done_next}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    check("scoreboard empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
